window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Consumer end of the line-buffer chain: two cascaded line_buffer stages feed this block, and it assembles their taps into a 3x3 RGB888 pixel window.
- Per accepted pixel column, it takes three vertically aligned pixels: two lines ago, one line ago, and the current line.
- It shifts these into a 3-column register array and emits the window with a valid strobe plus an end-of-frame pulse.
- It sits between the line buffers and the Gaussian kernel arithmetic.

Parameters:
- PIX_W, 24, bits per pixel (RGB888).
- DIM_W, 11, width of the image dimension inputs and internal counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- img_width  input  DIM_W  pixels per line; sampled on the first valid_i of a frame.
- img_height  input  DIM_W  lines per frame; sampled on the first valid_i of a frame.
- valid_i  input  1  all three taps valid this cycle (valid_o of the second line buffer).
- row0_i  input  PIX_W  pixel from two lines ago (oldest).
- row1_i  input  PIX_W  pixel from one line ago.
- row2_i  input  PIX_W  current-line pixel.
- valid_o  output  1  win_o holds a complete window.
- win_o  output  9*PIX_W  window; element k = 3*r + c at [PIX_W*k +: PIX_W]; r=0 oldest row, c=0 leftmost (oldest) column.
- frame_done_o  output  1  one-cycle pulse after the last window of a frame.

Behaviour:
- Reset is synchronous, active-high. It applies in any state, including mid-frame. Reset values:
  - state=IDLE, col_cnt=0, line_cnt=0
  - win_o=0, valid_o=0, frame_done_o=0
  - latched width/height=0
  - Partial frame is discarded.
- Input accounting:
  - valid_i arrives only for image rows 2..H-1, i.e. H-2 lines of W pixels.
  - No backpressure; valid_i may deassert at any cycle, including inside a line. Gaps hold all state.
- Column shift on each valid_i:
  - col0 <= col1, col1 <= col2, col2 <= {row0_i,row1_i,row2_i}.
  - win_o is the shift array itself, so latency is 1 cycle from valid_i to win_o/valid_o.
- valid_o:
  - Registered. Set in the cycle after valid_i accepted with col_cnt >= 2 (col_cnt = index of the accepted pixel).
  - Otherwise 0. It is never held high across an idle cycle.
- Counters:
  - col_cnt increments per valid_i. When col_cnt == W-1 it wraps to 0 and line_cnt increments.
  - col_cnt never exceeds W-1.
- State machine:
  - IDLE: on valid_i, latch W = img_width and H = img_height, process the pixel as col 0 / line 0, go to RUN.
  - RUN: on the valid_i where col_cnt == W-1 and line_cnt == H-3, go to DONE.
  - DONE: frame_done_o=1 for exactly one cycle (the same cycle as the final valid_o), then IDLE.
  - valid_i arriving in DONE is accepted as pixel 0 of the next frame (back-to-back frames, no bubble).
- Per-frame output: (W-2)*(H-2) windows.
- Degenerate sizes: W < 3 or H < 3 produce no valid_o. frame_done_o still pulses after W*max(H-2,1) accepted pixels.
- img_width/img_height changes mid-frame are ignored until the next IDLE->RUN transition.
- Column register contents are not cleared at line wrap. Windows are only flagged valid from col 2 onward, so stale data never appears with valid_o=1.

Optional Feature:
- Macro: WINDOW_EDGE_REPLICATE_EN.
- Defined:
  - At col 0, all three columns load the new tap.
  - At col 1, the normal shift applies, giving columns p0,p0,p1.
  - valid_o asserts for every accepted pixel: W*(H-2) windows per frame.
  - Degenerate rule becomes W >= 1.
- Undefined: the behaviour above, with no replication logic.

Test Plan:
- W=5, H=4, 10 contiguous valid_i, taps = (line,col)-coded values -> 6 valid_o pulses, each 1 cycle after its input. First window columns hold cols 0,1,2 of line 0. frame_done_o coincides with the 6th pulse.
- Same frame with valid_i toggled 1,0,1,0... -> identical 6 windows in order; valid_o never asserted on gap-following cycles.
- Reset asserted after 7 pixels of W=5,H=4, then a full new frame -> no output after reset; new frame yields exactly 6 windows starting from its col 2.
- Two back-to-back frames, W=4,H=3 then W=6,H=3 with no gap -> 2 windows + frame_done, then 4 windows + frame_done. Second sizes are latched at the start of the second frame.
- W=2, H=5, 6 pixels -> zero valid_o; frame_done_o after the 6th pixel.
- With WINDOW_EDGE_REPLICATE_EN, W=4,H=3, pixels p0..p3 -> 4 windows; first = (p0,p0,p0), second = (p0,p0,p1), fourth = (p1,p2,p3).

Source files
------------

// File: rtl/window_3x3_gen.sv
// Purpose : assembles three vertically aligned line-buffer taps into a 3x3 RGB888 window
//           for the Gaussian kernel stage.
// Latency : 1 cycle from an accepted valid_i to win_o/valid_o.
// Backpressure: none; gaps in valid_i simply hold all state.
// Optional: define WINDOW_EDGE_REPLICATE_EN to replicate the left-edge pixel so that
//           every accepted pixel produces a window (columns p0,p0,p0 then p0,p0,p1 ...).
// Ports   : clk/reset (sync, active-high); img_width/img_height sampled on the first
//           valid_i of a frame; valid_i + row0_i (oldest) / row1_i / row2_i (current line)
//           taps; valid_o + win_o (element 3*r+c at [PIX_W*k +: PIX_W]); frame_done_o pulse
//           coincident with the final window of the frame.
module window_3x3_gen #(
    parameter int PIX_W = 24,
    parameter int DIM_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIM_W-1:0]   img_width,
    input  logic [DIM_W-1:0]   img_height,
    input  logic               valid_i,
    input  logic [PIX_W-1:0]   row0_i,
    input  logic [PIX_W-1:0]   row1_i,
    input  logic [PIX_W-1:0]   row2_i,
    output logic               valid_o,
    output logic [9*PIX_W-1:0] win_o,
    output logic               frame_done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   col_q, col_d;
    logic [DIM_W-1:0]   line_q, line_d;
    logic [DIM_W-1:0]   w_q, w_d;
    logic [DIM_W-1:0]   h_q, h_d;
    logic               valid_q, valid_d;
    // tap_q[c][r]: column c (0 = oldest/leftmost), row r (0 = oldest line)
    logic [PIX_W-1:0]   tap_q [3][3];

    // The pixel being accepted is either the first of a new frame (IDLE/DONE) or
    // a continuation of the running frame; resolve which counters/sizes apply.
    logic               start;
    logic [DIM_W-1:0]   cur_w, cur_h, cur_col, cur_line;
    logic [DIM_W-1:0]   last_col, last_line;
    logic               eol, eof, h_ok, win_ok;

    always_comb begin
        start    = (state_q != RUN);
        cur_w    = start ? img_width  : w_q;
        cur_h    = start ? img_height : h_q;
        cur_col  = start ? '0 : col_q;
        cur_line = start ? '0 : line_q;
        // Degenerate sizes: W<=1 means one pixel per line, H<3 means a single line.
        last_col  = (cur_w <= DIM_W'(1)) ? '0 : cur_w - DIM_W'(1);
        last_line = (cur_h >= DIM_W'(3)) ? cur_h - DIM_W'(3) : '0;
        eol       = (cur_col == last_col);
        eof       = eol && (cur_line == last_line);
        h_ok      = (cur_h >= DIM_W'(3));
`ifdef WINDOW_EDGE_REPLICATE_EN
        win_ok    = h_ok && (cur_w != '0);
`else
        win_ok    = h_ok && (cur_col >= DIM_W'(2));
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pixel arriving in DONE starts the next frame directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_i) state_d = eof ? DONE : RUN;
            end
            RUN: begin
                if (valid_i && eof) state_d = DONE;
            end
            DONE: begin
                if (valid_i) state_d = eof ? DONE : RUN;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter / size / valid next-state
    always_comb begin
        col_d   = col_q;
        line_d  = line_q;
        w_d     = w_q;
        h_d     = h_q;
        valid_d = 1'b0;
        if (valid_i) begin
            w_d     = cur_w;
            h_d     = cur_h;
            valid_d = win_ok;
            if (eof) begin
                col_d  = '0;
                line_d = '0;
            end else if (eol) begin
                col_d  = '0;
                line_d = cur_line + DIM_W'(1);
            end else begin
                col_d  = cur_col + DIM_W'(1);
                line_d = cur_line;
            end
        end
    end

    // Datapath registers; taps are not cleared at line wrap since valid_d
    // already masks windows that still contain the previous line's columns.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            line_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            valid_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    tap_q[c][r] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            line_q  <= line_d;
            w_q     <= w_d;
            h_q     <= h_d;
            valid_q <= valid_d;
            if (valid_i) begin
`ifdef WINDOW_EDGE_REPLICATE_EN
                if (cur_col == '0) begin
                    tap_q[0][0] <= row0_i;
                    tap_q[0][1] <= row1_i;
                    tap_q[0][2] <= row2_i;
                    tap_q[1][0] <= row0_i;
                    tap_q[1][1] <= row1_i;
                    tap_q[1][2] <= row2_i;
                end else begin
                    tap_q[0] <= tap_q[1];
                    tap_q[1] <= tap_q[2];
                end
`else
                tap_q[0] <= tap_q[1];
                tap_q[1] <= tap_q[2];
`endif
                tap_q[2][0] <= row0_i;
                tap_q[2][1] <= row1_i;
                tap_q[2][2] <= row2_i;
            end
        end
    end

    // Outputs
    always_comb begin
        valid_o      = valid_q;
        frame_done_o = (state_q == DONE);
        win_o        = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_o[PIX_W*(3*r+c) +: PIX_W] = tap_q[c][r];
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Purpose : directed self-checking bench for window_3x3_gen.
// Latency : outputs sampled 1 time unit after the edge that accepts each pixel.
// Backpressure: none; gaps are driven as valid_i=0 cycles.
module tb_window_3x3_gen;

    localparam int PIX_W = 24;
    localparam int DIM_W = 11;

    logic               clk;
    logic               reset;
    logic [DIM_W-1:0]   img_width;
    logic [DIM_W-1:0]   img_height;
    logic               valid_i;
    logic [PIX_W-1:0]   row0_i, row1_i, row2_i;
    logic               valid_o;
    logic [9*PIX_W-1:0] win_o;
    logic               frame_done_o;

    int errors = 0;
    int checks = 0;

    window_3x3_gen #(.PIX_W(PIX_W), .DIM_W(DIM_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .img_width    (img_width),
        .img_height   (img_height),
        .valid_i      (valid_i),
        .row0_i       (row0_i),
        .row1_i       (row1_i),
        .row2_i       (row2_i),
        .valid_o      (valid_o),
        .win_o        (win_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pixel code: frame tag, image line, column.
    function automatic logic [PIX_W-1:0] pix(input int f, input int ln, input int c);
        return {8'(f), 8'(ln), 8'(c)};
    endfunction

    // Window ending at column c of window-line l; columns left of 0 clamp to 0.
    function automatic logic [9*PIX_W-1:0] exp_win(input int f, input int l, input int c);
        logic [9*PIX_W-1:0] w;
        int src;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int cc = 0; cc < 3; cc++) begin
                src = c - 2 + cc;
                if (src < 0) src = 0;
                w[PIX_W*(3*r+cc) +: PIX_W] = pix(f, l + r, src);
            end
        end
        return w;
    endfunction

    // One clock: drive a pixel (or a gap when v=0), then check the outputs.
    task automatic px(input bit v, input int f, input int l, input int c,
                      input bit ev, input bit ed);
        valid_i = v;
        row0_i  = pix(f, l, c);
        row1_i  = pix(f, l + 1, c);
        row2_i  = pix(f, l + 2, c);
        @(posedge clk);
        #1;
        check_eq($sformatf("valid f%0d l%0d c%0d v%0d", f, l, c, v), {255'd0, valid_o}, {255'd0, ev});
        check_eq($sformatf("done f%0d l%0d c%0d v%0d", f, l, c, v), {255'd0, frame_done_o}, {255'd0, ed});
        if (ev) check_eq($sformatf("win f%0d l%0d c%0d", f, l, c), {40'd0, win_o}, {40'd0, exp_win(f, l, c)});
        valid_i = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " valid"}, {255'd0, valid_o}, 256'd0);
        check_eq({tag, " done"},  {255'd0, frame_done_o}, 256'd0);
        check_eq({tag, " win"},   {40'd0, win_o}, 256'd0);
    endtask

    initial begin
        reset      = 1'b1;
        valid_i    = 1'b0;
        img_width  = 11'd5;
        img_height = 11'd4;
        row0_i     = '0;
        row1_i     = '0;
        row2_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

`ifdef WINDOW_EDGE_REPLICATE_EN
        // W=4,H=3: one window per pixel, left edge replicated.
        img_width  = 11'd4;
        img_height = 11'd3;
        for (int c = 0; c < 4; c++) px(1'b1, 8, 0, c, 1'b1, c == 3);
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);
        // W=2,H=5: replication still gives a window for every pixel.
        img_width  = 11'd2;
        img_height = 11'd5;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 2; c++) px(1'b1, 9, l, c, 1'b1, (l == 2) && (c == 1));
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);
`else
        // W=5,H=4 contiguous: 6 windows, done with the 6th.
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 5; c++) px(1'b1, 1, l, c, c >= 2, (l == 1) && (c == 4));
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Same frame with a gap after every pixel.
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 5; c++) begin
                px(1'b1, 2, l, c, c >= 2, (l == 1) && (c == 4));
                px(1'b0, 2, l, c, 1'b0, 1'b0);
            end

        // Reset after 7 pixels, then a full new frame.
        for (int i = 0; i < 7; i++) px(1'b1, 3, i / 5, i % 5, (i % 5) >= 2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midframe reset");
        reset = 1'b0;
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 5; c++) px(1'b1, 4, l, c, c >= 2, (l == 1) && (c == 4));
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Back-to-back W=4,H=3 then W=6,H=3; width changed mid-frame is ignored.
        img_width  = 11'd4;
        img_height = 11'd3;
        px(1'b1, 5, 0, 0, 1'b0, 1'b0);
        img_width  = 11'd6;
        for (int c = 1; c < 4; c++) px(1'b1, 5, 0, c, c >= 2, c == 3);
        for (int c = 0; c < 6; c++) px(1'b1, 6, 0, c, c >= 2, c == 5);
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);

        // Degenerate W=2,H=5: no windows, done after 6 pixels.
        img_width  = 11'd2;
        img_height = 11'd5;
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < 2; c++) px(1'b1, 7, l, c, 1'b0, (l == 2) && (c == 1));
        px(1'b0, 0, 0, 0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
